// File: rtl/dm_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state,
// word geometry, byte-lane merge and the store-trace text.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int WORD_BYTES = 4;

  // Enabled lanes take the new byte; disabled lanes keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

`ifndef SYNTHESIS
  function automatic string trace_line(input logic [31:0] pc,
                                       input logic [31:0] addr,
                                       input logic [31:0] data);
    return $sformatf("@%h: *%h <= %h", pc, addr, data);
  endfunction
`endif

endpackage

// File: rtl/dm_responder_array.sv
// Word-organised storage: asynchronous clear, synchronous byte-enabled
// write and combinational read through a single shared address.
module dm_responder_array
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= merge_bytes(mem[addr], wdata, be);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU load/store interface: accepts one request, waits
// LATENCY cycles, commits a byte-enabled store or a word load, then responds.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; the sender holds its payload stable until that edge.

  localparam logic [32:0] RANGE_BYTES = 33'(WORD_BYTES) << ADDR_W;

  dm_state_e   state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;

  logic        idle;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_pc;
  logic [31:0] offset;
  logic        cur_err;
  logic        enter_resp;
  logic        mem_we;
  logic [31:0] rd_word;
  logic [31:0] load_data;

  // With LATENCY=0 the commit edge is the accept edge, so the request fields
  // come straight from the port instead of the latches.
  assign idle      = (state == IDLE);
  assign cur_we    = idle ? req_we    : lat_we;
  assign cur_be    = idle ? req_be    : lat_be;
  assign cur_addr  = idle ? req_addr  : lat_addr;
  assign cur_wdata = idle ? req_wdata : lat_wdata;
  assign cur_pc    = idle ? req_pc    : lat_pc;

  assign offset     = cur_addr - BASE_ADDR;
  assign cur_err    = (cur_addr[1:0] != 2'b00) || ({1'b0, offset} >= RANGE_BYTES);
  assign enter_resp = (idle && req_valid && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));
  assign mem_we     = enter_resp && cur_we && !cur_err && (cur_be != 4'b0000);
  assign load_data  = (cur_we || cur_err) ? 32'h0 : rd_word;

  dm_responder_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .be    (cur_be),
    .addr  (offset[ADDR_W+1:2]),
    .wdata (cur_wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_be    <= req_be;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_pc    <= req_pc;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= cur_err;
              rsp_rdata <= load_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_rdata <= load_data;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      $display("%s", trace_line(cur_pc, {cur_addr[31:2], 2'b00},
                                merge_bytes(rd_word, cur_wdata, cur_be)));
    end
  end
`endif

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the slave end of the load/store request interface driven by the CPU datapath.
- Accepts one word request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then performs a byte-enabled write or a full-word read.
- Returns the result over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core and its stall logic can be exercised against a multi-cycle memory.

Parameters:
- ADDR_W, 12, word-index width; capacity is 2**ADDR_W words (16 KiB at default).
- LATENCY, 2, wait cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and the memory array.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_be  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i); ignored for loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_pc  in  32  PC of the issuing instruction, used for the write trace.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0.
  - Every memory word is set to 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid in cycle t, the request is accepted: latch we, be, addr, wdata, pc.
  - Load the counter with LATENCY.
  - Go to WAIT, or to RESP directly if LATENCY=0.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - When the counter reaches 1, the next edge goes to RESP.
- Latency: rsp_valid first rises in cycle t+1+LATENCY.
- Commit (the edge that enters RESP):
  - Store: each enabled byte lane is written; disabled lanes keep their old value.
  - Load: rsp_rdata captures the full addressed word.
  - Store trace: $display("@%h: *%h <= %h", pc, word-aligned addr, merged word).
  - A store with be=4'b0000 completes normally, writes nothing and prints nothing.
- Error: rsp_err=1 if either condition holds:
  - addr[1:0]!=0 (misaligned), or
  - (addr-BASE_ADDR) >= 4*2**ADDR_W (unsigned 32-bit compare; wraps below BASE_ADDR count as out of range).
  - On error: no write, no trace, rsp_rdata=0. Latency is unchanged.
- Word index = (addr-BASE_ADDR)[ADDR_W+1:2].
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - The handshake edge returns to IDLE and clears rsp_valid, rsp_rdata and rsp_err.
  - req_ready=0 throughout RESP.
  - No pipelining: a new request can be accepted no earlier than the cycle after the response handshake.
- Back-to-back: with rsp_ready held high, requests are accepted every LATENCY+2 cycles.
- Reset mid-operation: a pending request in WAIT or RESP is discarded. No write occurs and no response is produced.
- A request held on req_valid during WAIT or RESP is not sampled; the requester must hold it until req_ready.
- Read-after-write: a load issued after a store's response handshake returns the merged data.

Decomposition:
- Package dm_responder_pkg:
  - State enum IDLE/WAIT/RESP (2 bits).
  - Constants WORD_BYTES=4 and trace format string.
  - Function for the byte-lane merge (old, new, be) -> word.
- Sub-module dm_responder_array:
  - Storage of 2**ADDR_W x 32.
  - Asynchronous-reset clear, synchronous byte-enabled write, combinational read.
- The FSM, counter, error check and trace stay in dm_responder.

Test Plan:
- Reset, then store: addr 0x0000_0010, wdata 0xDEAD_BEEF, be 4'hF, pc 0x0000_3000, LATENCY=2.
  - rsp_valid rises 3 cycles after acceptance; rsp_err=0.
  - Trace "@00003000: *00000010 <= deadbeef".
  - A following load of 0x10 returns 0xDEAD_BEEF.
- Partial store over 0xDEAD_BEEF at 0x10: be 4'b0010, wdata 0x0000_AA00.
  - A following load returns 0xDEAD_AAEF.
- Misaligned load of 0x0000_0012 -> rsp_err=1, rsp_rdata=0.
  - Store of 0x0001_0000 (out of range at ADDR_W=12) -> rsp_err=1; memory and trace unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid/rsp_rdata stay stable; req_ready stays 0; a req_valid pulse in that window is ignored.
  - Handshake -> req_ready=1 the next cycle.
- Reset during WAIT of a store to 0x20 (wdata 0x1234_5678).
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - No trace; a later load of 0x20 returns 0.
- LATENCY=0 build: accept in cycle t -> rsp_valid in cycle t+1.
  - With rsp_ready=1, a second request is accepted in cycle t+2.
